// File: rtl/ring_pkg.sv
// Shared state encodings and ring rotate helpers for the ring subsystem.
package ring_pkg;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Helpers operate on a 32-bit container; w gives the live ring width (2..32).
  localparam int RMAX = 32;

  function automatic logic [RMAX-1:0] ring_mask(input int w);
    return (w >= RMAX) ? '1 : ((RMAX'(1) << w) - RMAX'(1));
  endfunction

  function automatic logic [RMAX-1:0] rot_l(input logic [RMAX-1:0] v, input int w);
    return ((v << 1) | (v >> (w - 1))) & ring_mask(w);
  endfunction

  function automatic logic [RMAX-1:0] rot_r(input logic [RMAX-1:0] v, input int w);
    return ((v >> 1) | (v << (w - 1))) & ring_mask(w);
  endfunction

endpackage

// File: rtl/ring_count_monitor_if.sv
// Sample/status bundle between a ring stream source and ring_count_monitor.
// RING_BIDIR_EN adds the captured direction output.
interface ring_count_monitor_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2,
  parameter int ERRW  = 8
);
  logic             en;
  logic [WIDTH-1:0] ring_in;
  logic             clr_err;
  logic [IDXW-1:0]  idx;
  logic             idx_vld;
  logic             locked;
  logic             seq_err;
  logic             illegal;
  logic [ERRW-1:0]  err_cnt;
`ifdef RING_BIDIR_EN
  logic             dir;
`endif

  modport master (
    output en, ring_in, clr_err,
`ifdef RING_BIDIR_EN
    input  dir,
`endif
    input  idx, idx_vld, locked, seq_err, illegal, err_cnt
  );

  modport slave (
    input  en, ring_in, clr_err,
`ifdef RING_BIDIR_EN
    output dir,
`endif
    output idx, idx_vld, locked, seq_err, illegal, err_cnt
  );
endinterface

// File: rtl/onehot_dec.sv
// One-hot to binary encoder; legal is high only when exactly one bit is set.
module onehot_dec #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
) (
  input  logic [WIDTH-1:0] ring,
  output logic [IDXW-1:0]  idx,
  output logic             legal
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ring[i]) idx = IDXW'(i);
  end

  assign legal = (ring != '0) && ((ring & (ring - WIDTH'(1))) == '0);
endmodule

// File: rtl/ring_count_monitor.sv
// Decoder and integrity monitor for a one-hot ring counter stream.
// Optional macro RING_BIDIR_EN: also lock onto rotate-right streams, reporting dir.
module ring_count_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDXW     = 2,
  parameter int LOCK_CNT = 2,
  parameter int ERRW     = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  ring_count_monitor_if.slave bus
);
  logic [0:0]       state;
  logic [2:0]       good;
  logic [2:0]       good_nx;
  logic [WIDTH-1:0] prev;
  logic [IDXW-1:0]  dec_idx;
  logic             legal;
  logic             step_up, hunt_ok, lock_ok, seq_fire;
  logic [IDXW-1:0]  idx_q;
  logic             idx_vld_q, seq_err_q, illegal_q;
  logic [ERRW-1:0]  err_q;

  onehot_dec #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec (
    .ring (bus.ring_in),
    .idx  (dec_idx),
    .legal(legal)
  );

  // A cleared prev (after reset or an illegal sample) can only seed, never match.
  assign step_up = (prev != '0) && (32'(bus.ring_in) == rot_l(32'(prev), WIDTH));
  assign good_nx = good + 3'd1;

`ifdef RING_BIDIR_EN
  logic dir_q;
  logic step_dn;
  assign step_dn = (prev != '0) && (32'(bus.ring_in) == rot_r(32'(prev), WIDTH));
  // First match of a run picks the direction; later steps must follow it.
  assign hunt_ok = (good == 3'd0) ? (step_up || step_dn) : (dir_q ? step_dn : step_up);
  assign lock_ok = dir_q ? step_dn : step_up;
  assign bus.dir = dir_q;
`else
  assign hunt_ok = step_up;
  assign lock_ok = step_up;
`endif

  assign seq_fire = bus.en && (!legal || (state == LOCKED && !lock_ok));

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state     <= HUNT;
      good      <= '0;
      prev      <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      seq_err_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef RING_BIDIR_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      idx_vld_q <= 1'b0;
      seq_err_q <= seq_fire;
      illegal_q <= bus.en && !legal;
      if (bus.en) begin
        if (!legal) begin
          state <= HUNT;
          good  <= '0;
          prev  <= '0;
        end else begin
          idx_q     <= dec_idx;
          idx_vld_q <= 1'b1;
          prev      <= bus.ring_in;
          if (state == HUNT) begin
            if (hunt_ok) begin
              good <= good_nx;
              if (good_nx == 3'(LOCK_CNT)) state <= LOCKED;
`ifdef RING_BIDIR_EN
              if (good == 3'd0) dir_q <= !step_up;
`endif
            end else begin
              good <= '0;
            end
          end else if (!lock_ok) begin
            state <= HUNT;
            good  <= '0;
          end
        end
      end
    end
  end

  // Clear takes priority, then the same-edge error still counts once.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)                        err_q <= '0;
    else if (bus.clr_err)             err_q <= seq_fire ? ERRW'(1) : '0;
    else if (seq_fire && err_q != '1) err_q <= err_q + ERRW'(1);
  end

  assign bus.idx     = idx_q;
  assign bus.idx_vld = idx_vld_q;
  assign bus.locked  = (state == LOCKED);
  assign bus.seq_err = seq_err_q;
  assign bus.illegal = illegal_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_ring_count_monitor.sv
// Directed bench for ring_count_monitor (WIDTH=4, LOCK_CNT=2, ERRW=8).
module tb_ring_count_monitor;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ring_count_monitor_if #(.WIDTH(4), .IDXW(2), .ERRW(8)) bus ();

  ring_count_monitor #(.WIDTH(4), .IDXW(2), .LOCK_CNT(2), .ERRW(8)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one strobe between edges, then look just after the sampling edge.
  task automatic step(input logic [3:0] r, input logic clr);
    @(negedge clk);
    bus.en = 1'b1; bus.ring_in = r; bus.clr_err = clr;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] idx, input logic vld,
                         input logic lck, input logic se, input logic il, input logic [7:0] ec);
    chk({tag, ".idx"},     32'(bus.idx),     32'(idx));
    chk({tag, ".idx_vld"}, 32'(bus.idx_vld), 32'(vld));
    chk({tag, ".locked"},  32'(bus.locked),  32'(lck));
    chk({tag, ".seq_err"}, 32'(bus.seq_err), 32'(se));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(il));
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(ec));
  endtask

  initial begin
    bus.en = 1'b0; bus.ring_in = '0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b0;
    #1 chk_all("reset", 2'd0, 0, 0, 0, 0, 8'd0);

    // Seed, then two good successors lock on the third sample.
    step(4'b0001, 0); chk_all("seed",   2'd0, 1, 0, 0, 0, 8'd0);
    step(4'b0010, 0); chk_all("step1",  2'd1, 1, 0, 0, 0, 8'd0);
    step(4'b0100, 0); chk_all("lock",   2'd2, 1, 1, 0, 0, 8'd0);
    @(posedge clk); #1;
    chk_all("idle", 2'd2, 0, 1, 0, 0, 8'd0);
    step(4'b1000, 0); chk_all("lk3",    2'd3, 1, 1, 0, 0, 8'd0);
    step(4'b0001, 0); chk_all("wrap",   2'd0, 1, 1, 0, 0, 8'd0);

    // Mismatch while locked reseeds from the bad sample.
    step(4'b0100, 0); chk_all("mism",   2'd2, 1, 0, 1, 0, 8'd1);
    step(4'b1000, 0); chk_all("rl1",    2'd3, 1, 0, 0, 0, 8'd1);
    step(4'b0001, 0); chk_all("relock", 2'd0, 1, 1, 0, 0, 8'd1);

    // Illegal samples: idx holds, FSM drops to HUNT.
    step(4'b0000, 0); chk_all("zero",   2'd0, 0, 0, 1, 1, 8'd2);
    step(4'b0110, 0); chk_all("multi",  2'd0, 0, 0, 1, 1, 8'd3);
    // prev was cleared, so this legal sample only seeds.
    step(4'b0010, 0); chk_all("reseed", 2'd1, 1, 0, 0, 0, 8'd3);

    // 3 + 260 errors saturates at 255.
    for (int i = 0; i < 260; i++) step(4'b1111, 0);
    chk_all("sat", 2'd1, 0, 0, 1, 1, 8'd255);
    step(4'b0000, 1); chk("clr+err", 32'(bus.err_cnt), 32'd1);
    @(negedge clk); bus.clr_err = 1'b1;
    @(posedge clk); #1 bus.clr_err = 1'b0;
    chk("clr", 32'(bus.err_cnt), 32'd0);

    // Async reset mid-lock, asserted away from any clock edge.
    step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0); step(4'b1100, 0);
    chk("pre_rst.err", 32'(bus.err_cnt), 32'd1);
    step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0);
    chk("pre_rst.lock", 32'(bus.locked), 32'd1);
    #2 n_rst = 1'b1;
    #1 chk_all("async", 2'd0, 0, 0, 0, 0, 8'd0);
    @(negedge clk); n_rst = 1'b0;
    step(4'b1000, 0); chk_all("post1", 2'd3, 1, 0, 0, 0, 8'd0);
    step(4'b0001, 0); chk_all("post2", 2'd0, 1, 0, 0, 0, 8'd0);
    step(4'b0010, 0); chk_all("post3", 2'd1, 1, 1, 0, 0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_count_monitor.md
Name: ring_count_monitor

Overview:
Receive-side checker for the ring-counter output stream.
- Samples a WIDTH-bit one-hot ring value on each enable strobe and decodes it to a binary index.
- Verifies that each sample is the rotate-left successor of the previous one.
- Reports lock status, sequence errors and a saturating error count.
- Sits downstream of the ring counter as its decoder and integrity monitor, alongside the binary counter in the ring subsystem.

Parameters:
WIDTH, 4, number of ring bits (≥2)
IDXW, 2, index width; must equal clog2(WIDTH)
LOCK_CNT, 2, consecutive correct successors needed to declare lock (1..7)
ERRW, 8, error counter width

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous reset, active-high (n_rst=1 resets)
en  in  1  sample strobe; ring_in is valid when en=1
ring_in  in  WIDTH  one-hot ring counter value
clr_err  in  1  synchronous clear of err_cnt
idx  out  IDXW  binary position of the set bit in the last legal sample
idx_vld  out  1  one-cycle pulse; idx updated from a legal sample
locked  out  1  high while FSM is in LOCKED
seq_err  out  1  one-cycle pulse on any sequence or legality error
illegal  out  1  one-cycle pulse when the sampled value is not one-hot
err_cnt  out  ERRW  saturating count of seq_err pulses

Behaviour:
- Reset: all outputs 0; FSM=HUNT; good-step counter=0; stored previous sample=0.
- All outputs are registered. Response appears on the clock edge that samples en=1, so it is visible one cycle after the strobe. With en=0, state and idx hold and all pulses are 0.
- Legality: a sample is legal iff exactly one bit is set. Zero or multi-hot samples:
  - illegal=1 and seq_err=1 (both pulses);
  - idx holds; idx_vld=0;
  - FSM goes to HUNT with the good-step counter cleared and the stored previous sample cleared.
- Expected successor: prev rotated left by 1, so bit WIDTH-1 wraps to bit 0. Index is (prev_idx+1) mod WIDTH.
- FSM states:
  - HUNT, legal sample:
    - If prev is nonzero and the sample equals the expected successor, the good counter increments. When it reaches LOCK_CNT, go to LOCKED (locked=1 on that same edge).
    - Otherwise the good counter resets to 0. No seq_err is raised in HUNT for mismatch.
    - In both cases the sample is stored as prev.
  - LOCKED, legal sample equal to expected: stay in LOCKED.
  - LOCKED, legal mismatch: seq_err=1; go to HUNT; good counter=0; the sample is stored as the new prev (reseed).
- idx_vld=1 on every legal sample in any state.
- err_cnt increments on each seq_err and saturates at all-ones.
- clr_err sets err_cnt to 0. If clr_err and seq_err occur on the same edge, the result is err_cnt=1 (the clear wins, then the increment applies).
- Assertion of n_rst mid-stream: immediate asynchronous return to the reset values. The first sample after reset can only seed prev; it cannot lock.

Optional Feature:
Macro RING_BIDIR_EN.
- Defined: the monitor also accepts a rotate-right (descending) sequence.
  - Output dir (1 bit, registered, reset 0) is added: 0=up, 1=down.
  - In HUNT, the direction of the first matching step is captured into dir.
  - In LOCKED, only the captured direction is accepted; a step in the opposite direction is a legal mismatch and raises seq_err.
- Undefined: only rotate-left is accepted, and the dir port does not exist.

Decomposition:
- Package ring_pkg: FSM state enum (HUNT, LOCKED) and a rotate-left/right function parameterised on WIDTH.
- Sub-module onehot_dec: combinational one-hot-to-binary encoder with a legal flag (popcount==1). It is instantiated once.

Test Plan:
- Reset, then en pulses with ring_in 0001,0010,0100 (WIDTH=4, LOCK_CNT=2) -> idx 0,1,2 with idx_vld each; locked rises on the edge sampling 0100; seq_err never set.
- Locked stream continues 1000,0001 -> idx 3 then 0 (wrap); locked stays 1; err_cnt=0.
- While locked, inject 0100 where 0010 is expected -> seq_err pulse, locked=0, err_cnt=1, idx=2. Then 1000,0001 -> relock on the second step.
- Inject 0000 then 0110 -> illegal and seq_err pulse on each, idx unchanged, err_cnt +2, FSM in HUNT.
- Drive 260 forced errors with ERRW=8 -> err_cnt saturates at 255. Pulse clr_err on the same edge as an error -> err_cnt=1.
- Assert n_rst mid-lock for one cycle, asynchronously -> all outputs 0 immediately. The next legal sample gives idx_vld with locked=0.
